pipeline_sequencer: RTL and testbench

//  Central stall/flush/halt sequencer for the 5-stage pipeline. Drives the per-bar

---
 rtl/pipeline_sequencer_pkg.sv | 18 +
 rtl/pipeline_sequencer_if.sv | 37 +++
 rtl/pipeline_sequencer_hazard_detect.sv | 14 +
 rtl/pipeline_sequencer.sv | 126 ++++++++++++
 tb/tb_pipeline_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and bar indices for the pipeline stall/flush/halt sequencer.
package pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } seqstate_t;

    localparam int REG_W     = 5;
    localparam int NUM_BARS  = 4;
    localparam int BAR_IFID  = 0;
    localparam int BAR_IDEX  = 1;
    localparam int BAR_EXMEM = 2;
    localparam int BAR_MEMWB = 3;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard sources in, per-bar enable/flush and status out; master side is the sequencer.
interface pipeline_sequencer_if
    import pipeline_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                ihit;
    logic                dhit;
    logic                dren_mem;
    logic                dwen_mem;
    logic                dren_ex;
    logic [REG_W-1:0]    wsel_ex;
    logic [REG_W-1:0]    rs_id;
    logic [REG_W-1:0]    rt_id;
    logic                redirect_mem;
    logic                halt_mem;
    logic                halt_wb;

    logic                pc_en;
    logic [NUM_BARS-1:0] en;
    logic [NUM_BARS-1:0] flush;
    logic                halted;
    logic                mem_timeout;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        input  ihit, dhit, dren_mem, dwen_mem, dren_ex, wsel_ex, rs_id, rt_id,
               redirect_mem, halt_mem, halt_wb,
        output pc_en, en, flush, halted, mem_timeout, stall_cnt
    );

    modport slave (
        output ihit, dhit, dren_mem, dwen_mem, dren_ex, wsel_ex, rs_id, rt_id,
               redirect_mem, halt_mem, halt_wb,
        input  pc_en, en, flush, halted, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds the instruction in ID.
module pipeline_sequencer_hazard_detect
    import pipeline_sequencer_pkg::*;
(
    input  logic             i_dren_ex,
    input  logic [REG_W-1:0] i_wsel_ex,
    input  logic [REG_W-1:0] i_rs_id,
    input  logic [REG_W-1:0] i_rt_id,
    output logic             o_lu_stall
);
    // r0 is hardwired, so a load targeting it never creates a dependency.
    assign o_lu_stall = i_dren_ex && (i_wsel_ex != '0) &&
                        ((i_wsel_ex == i_rs_id) || (i_wsel_ex == i_rt_id));
endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush/halt sequencer: FSM, dmem wait watchdog and stall counter.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    pipeline_sequencer_if.master bus
);
    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0]  STALL_MAX = '1;

    seqstate_t           r_state;
    seqstate_t           w_state_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_next;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                r_mem_timeout;
    logic                w_timeout_set;
    logic                w_stall_inc;
    logic                w_lu_stall;
    logic                w_mem_miss;
    logic                w_pc_en;
    logic [NUM_BARS-1:0] w_en;
    logic [NUM_BARS-1:0] w_flush;

    pipeline_sequencer_hazard_detect u_hazard_detect (
        .i_dren_ex  (bus.dren_ex),
        .i_wsel_ex  (bus.wsel_ex),
        .i_rs_id    (bus.rs_id),
        .i_rt_id    (bus.rt_id),
        .o_lu_stall (w_lu_stall)
    );

    assign w_mem_miss = (bus.dren_mem | bus.dwen_mem) & ~bus.dhit;

    always_comb begin
        w_state_next = r_state;
        w_pc_en      = 1'b0;
        w_en         = '0;
        w_flush      = '0;
        unique case (r_state)
            RUN, MEM_WAIT: begin
                if ((r_state == RUN) && bus.halt_mem) begin
                    w_state_next       = DRAIN;
                    w_en               = '1;
                    w_flush[BAR_IFID]  = 1'b1;
                    w_flush[BAR_IDEX]  = 1'b1;
                end else if ((r_state == MEM_WAIT) ? !bus.dhit : w_mem_miss) begin
                    w_state_next = MEM_WAIT;
                end else begin
                    // Also the dhit cycle out of MEM_WAIT: bars advance this same cycle.
                    w_state_next = RUN;
                    w_en         = '1;
                    if (bus.redirect_mem) begin
                        w_pc_en            = 1'b1;
                        w_flush[BAR_IFID]  = 1'b1;
                        w_flush[BAR_IDEX]  = 1'b1;
                        w_flush[BAR_EXMEM] = 1'b1;
                    end else if (w_lu_stall) begin
                        w_en[BAR_IFID]     = 1'b0;
                        w_flush[BAR_IDEX]  = 1'b1;
                    end else if (!bus.ihit) begin
                        w_flush[BAR_IFID]  = 1'b1;
                    end else begin
                        w_pc_en            = 1'b1;
                    end
                end
            end
            DRAIN: begin
                w_en[BAR_IFID]     = 1'b1;
                w_en[BAR_IDEX]     = 1'b1;
                w_en[BAR_EXMEM]    = ~w_mem_miss;
                w_en[BAR_MEMWB]    = ~w_mem_miss;
                w_flush[BAR_IFID]  = 1'b1;
                w_flush[BAR_IDEX]  = 1'b1;
                if (bus.halt_wb) begin
                    w_state_next = HALTED;
                end
            end
            HALTED: begin
                w_state_next = HALTED;
            end
        endcase
    end

    // The wait count includes the cycle that first sees the miss.
    always_comb begin
        w_wait_cnt_next = '0;
        if (w_state_next == MEM_WAIT) begin
            w_wait_cnt_next = (r_wait_cnt == WAIT_LIM) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
        end
        w_timeout_set = (WAIT_MAX != 0) && (w_state_next == MEM_WAIT) &&
                        (w_wait_cnt_next == WAIT_LIM);
        w_stall_inc   = ((r_state == RUN) || (r_state == MEM_WAIT)) && !w_pc_en &&
                        (r_stall_cnt != STALL_MAX);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.en          = w_en;
    assign bus.flush       = w_flush;
    assign bus.halted      = (r_state == HALTED);
    assign bus.mem_timeout = r_mem_timeout;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: vector table, directed corner sequences, random vs. rule model.
`timescale 1ns/1ps
module tb_pipeline_sequencer;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       dren_mem;
        logic       dwen_mem;
        logic       dren_ex;
        logic [4:0] wsel_ex;
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       redirect_mem;
        logic       halt_mem;
        logic       halt_wb;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       pc;
        logic [3:0] en;
        logic [3:0] fl;
        int         stall;
    } vec_t;

    typedef struct {
        bit waiting;
        bit draining;
        bit stopped;
        int waited;
        int stalls;
        bit timeout;
    } model_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    stim_t cur;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    step_no  = 0;
    model_t m_a, m_b, n_a, n_b;
    vec_t  vecs[18];

    always #5 clk = ~clk;

    pipeline_sequencer_if #(.CNT_W(16)) if_a ();
    pipeline_sequencer_if #(.CNT_W(4))  if_b ();

    pipeline_sequencer #(.CNT_W(16), .WAIT_MAX(255)) u_dut_a (.i_clk(clk), .i_rst(rst), .bus(if_a));
    pipeline_sequencer #(.CNT_W(4),  .WAIT_MAX(3))   u_dut_b (.i_clk(clk), .i_rst(rst), .bus(if_b));

    assign if_a.ihit = cur.ihit;                 assign if_b.ihit = cur.ihit;
    assign if_a.dhit = cur.dhit;                 assign if_b.dhit = cur.dhit;
    assign if_a.dren_mem = cur.dren_mem;         assign if_b.dren_mem = cur.dren_mem;
    assign if_a.dwen_mem = cur.dwen_mem;         assign if_b.dwen_mem = cur.dwen_mem;
    assign if_a.dren_ex = cur.dren_ex;           assign if_b.dren_ex = cur.dren_ex;
    assign if_a.wsel_ex = cur.wsel_ex;           assign if_b.wsel_ex = cur.wsel_ex;
    assign if_a.rs_id = cur.rs_id;               assign if_b.rs_id = cur.rs_id;
    assign if_a.rt_id = cur.rt_id;               assign if_b.rt_id = cur.rt_id;
    assign if_a.redirect_mem = cur.redirect_mem; assign if_b.redirect_mem = cur.redirect_mem;
    assign if_a.halt_mem = cur.halt_mem;         assign if_b.halt_mem = cur.halt_mem;
    assign if_a.halt_wb = cur.halt_wb;           assign if_b.halt_wb = cur.halt_wb;

    function automatic stim_t mk(input bit ih, input bit dh, input bit drm, input bit dwm,
                                 input bit dre, input int ws, input int rs, input int rt,
                                 input bit rd, input bit hm, input bit hw);
        stim_t s;
        s = '{ih, dh, drm, dwm, dre, 5'(ws), 5'(rs), 5'(rt), rd, hm, hw};
        return s;
    endfunction

    function automatic logic [31:0] pack(input logic pc, input logic [3:0] en, input logic [3:0] fl,
                                         input logic h, input logic t, input logic [15:0] st);
        return {5'd0, pc, en, fl, h, t, st};
    endfunction

    function automatic logic [31:0] obs_a();
        return pack(if_a.pc_en, if_a.en, if_a.flush, if_a.halted, if_a.mem_timeout, if_a.stall_cnt);
    endfunction

    function automatic logic [31:0] obs_b();
        return pack(if_b.pc_en, if_b.en, if_b.flush, if_b.halted, if_b.mem_timeout, {12'd0, if_b.stall_cnt});
    endfunction

    // Rule model: outputs for this cycle plus the model state after the clock edge.
    function automatic void model_eval(input stim_t s, input model_t m, input int wmax, input int smax,
                                       output logic [31:0] exp, output model_t n);
        bit lu, miss, pc;
        bit [3:0] en, fl;
        n  = m;
        pc = 1'b0;
        en = 4'h0;
        fl = 4'h0;
        lu   = s.dren_ex && (s.wsel_ex != 5'd0) && ((s.wsel_ex == s.rs_id) || (s.wsel_ex == s.rt_id));
        miss = (s.dren_mem || s.dwen_mem) && !s.dhit;
        if (m.stopped) begin
            pc = 1'b0;
        end else if (m.draining) begin
            fl = 4'b0011;
            en = miss ? 4'b0011 : 4'b1111;
            if (s.halt_wb) begin
                n.draining = 1'b0;
                n.stopped  = 1'b1;
            end
        end else begin
            if (!m.waiting && s.halt_mem) begin
                en = 4'hF; fl = 4'b0011; n.draining = 1'b1;
            end else if (m.waiting ? !s.dhit : miss) begin
                n.waiting = 1'b1;
                n.waited  = (m.waited + 1 > wmax) ? wmax : m.waited + 1;
                if (wmax != 0 && n.waited == wmax) n.timeout = 1'b1;
            end else begin
                n.waiting = 1'b0;
                n.waited  = 0;
                if (s.redirect_mem) begin
                    pc = 1'b1; en = 4'hF; fl = 4'b0111;
                end else if (lu) begin
                    en = 4'b1110; fl = 4'b0010;
                end else if (!s.ihit) begin
                    en = 4'hF; fl = 4'b0001;
                end else begin
                    pc = 1'b1; en = 4'hF;
                end
            end
            if (!pc && m.stalls < smax) n.stalls = m.stalls + 1;
        end
        exp = pack(pc, en, fl, m.stopped, m.timeout, 16'(m.stalls));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %h, expected %h", name, step_no, act, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '{default: 0};
        m_b = '{default: 0};
    endtask

    task automatic settle();
        logic [31:0] ea, eb;
        @(negedge clk);
        model_eval(cur, m_a, 255, 65535, ea, n_a);
        model_eval(cur, m_b, 3, 15, eb, n_b);
        check("model_a", obs_a(), ea);
        check("model_b", obs_b(), eb);
        step_no++;
        $display("step %0d stim=%h dut_a=%h dut_b=%h", step_no, cur, obs_a(), obs_b());
    endtask

    task automatic advance();
        @(posedge clk);
        m_a = n_a;
        m_b = n_b;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.ihit         = ($urandom_range(99, 0) < 85);
        s.dhit         = ($urandom_range(99, 0) < 50);
        s.dren_mem     = ($urandom_range(99, 0) < 20);
        s.dwen_mem     = ($urandom_range(99, 0) < 10);
        s.dren_ex      = ($urandom_range(99, 0) < 40);
        s.wsel_ex      = 5'($urandom_range(3, 0));
        s.rs_id        = 5'($urandom_range(3, 0));
        s.rt_id        = 5'($urandom_range(3, 0));
        s.redirect_mem = ($urandom_range(99, 0) < 15);
        s.halt_mem     = ($urandom_range(99, 0) < 2);
        s.halt_wb      = ($urandom_range(99, 0) < 15);
        return s;
    endfunction

    initial begin
        cur = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset held for three clock edges; outputs follow the idle RUN decode.
        @(negedge clk);
        check("reset_a", obs_a(), pack(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 16'd0));
        check("reset_b", obs_b(), pack(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 16'd0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // args: ihit dhit dren_mem dwen_mem dren_ex wsel rs rt redirect halt_mem halt_wb
        vecs[0]  = '{mk(1,0,0,0,0,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 0};
        vecs[1]  = '{mk(1,0,0,0,1,5,5,0,0,0,0), 1'b0, 4'hE, 4'h2, 0};
        vecs[2]  = '{mk(1,0,0,0,0,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 1};
        vecs[3]  = '{mk(1,0,0,0,1,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 1};
        vecs[4]  = '{mk(1,0,0,0,1,7,3,7,0,0,0), 1'b0, 4'hE, 4'h2, 1};
        vecs[5]  = '{mk(1,0,0,0,1,9,9,0,1,0,0), 1'b1, 4'hF, 4'h7, 2};
        vecs[6]  = '{mk(1,0,0,0,0,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 2};
        vecs[7]  = '{mk(0,0,0,0,0,0,0,0,0,0,0), 1'b0, 4'hF, 4'h1, 2};
        vecs[8]  = '{mk(1,0,0,0,0,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 3};
        vecs[9]  = '{mk(1,1,0,1,0,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 3};
        vecs[10] = '{mk(0,0,1,0,0,0,0,0,0,0,0), 1'b0, 4'h0, 4'h0, 3};
        vecs[11] = '{mk(0,1,1,0,0,0,0,0,0,0,0), 1'b0, 4'hF, 4'h1, 4};
        vecs[12] = '{mk(1,0,0,0,0,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 5};
        vecs[13] = '{mk(0,0,0,0,1,4,0,4,0,0,0), 1'b0, 4'hE, 4'h2, 5};
        vecs[14] = '{mk(1,0,0,0,0,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 6};
        vecs[15] = '{mk(1,0,0,1,1,4,4,0,1,0,0), 1'b0, 4'h0, 4'h0, 6};
        vecs[16] = '{mk(1,1,0,1,1,4,4,0,1,0,0), 1'b1, 4'hF, 4'h7, 7};
        vecs[17] = '{mk(1,0,0,0,0,0,0,0,0,0,0), 1'b1, 4'hF, 4'h0, 7};

        for (int i = 0; i < 18; i++) begin
            cur = vecs[i].s;
            settle();
            check($sformatf("vec%0d", i), {if_a.pc_en, if_a.en, if_a.flush, if_a.stall_cnt},
                  {vecs[i].pc, vecs[i].en, vecs[i].fl, 16'(vecs[i].stall)});
            advance();
        end

        // dmem miss held for four cycles, then completed.
        cur = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("wait_bars", {27'd0, if_a.pc_en, if_a.en}, 32'd0);
            check("wait_stall", {16'd0, if_a.stall_cnt}, 32'(7 + c));
            check("wait_timeout_b", {31'd0, if_b.mem_timeout}, 32'(c == 3));
            advance();
        end
        cur.dhit = 1'b1;
        settle();
        check("dhit_bars", {27'd0, if_a.pc_en, if_a.en}, {27'd0, 1'b1, 4'hF});
        check("dhit_stall", {16'd0, if_a.stall_cnt}, 32'd11);
        check("timeout_a_off", {31'd0, if_a.mem_timeout}, 32'd0);
        advance();
        cur = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("timeout_b_sticky", {31'd0, if_b.mem_timeout}, 32'd1);
        advance();

        // Asynchronous reset while waiting on dmem.
        cur = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        advance();
        settle();
        advance();
        cur.dren_mem = 1'b0;
        #1;
        check("wait_holds", {28'd0, if_a.en}, 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_bars", {27'd0, if_a.pc_en, if_a.en}, {27'd0, 1'b1, 4'hF});
        check("async_rst_stall", {16'd0, if_a.stall_cnt}, 32'd0);
        check("async_rst_timeout", {31'd0, if_b.mem_timeout}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Halt (with a coincident redirect), drain with a dmem miss, then stop.
        cur = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        settle();
        check("halt_enter", {23'd0, if_a.pc_en, if_a.en, if_a.flush}, {23'd0, 1'b0, 4'hF, 4'h3});
        advance();
        cur = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("drain_miss", {23'd0, if_a.pc_en, if_a.en, if_a.flush}, {23'd0, 1'b0, 4'h3, 4'h3});
        check("drain_stall", {16'd0, if_a.stall_cnt}, 32'd1);
        advance();
        cur = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        settle();
        check("drain_last", {22'd0, if_a.halted, if_a.pc_en, if_a.en, if_a.flush},
              {22'd0, 1'b0, 1'b0, 4'hF, 4'h3});
        advance();
        cur = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            settle();
            check("halted", {22'd0, if_a.halted, if_a.pc_en, if_a.en, if_a.flush}, {22'd0, 1'b1, 9'd0});
            check("halted_stall", {16'd0, if_a.stall_cnt}, 32'd1);
            advance();
        end

        // Random traffic against the rule model, with periodic resets to leave HALTED.
        for (int blk = 0; blk < 5; blk++) begin
            do_reset();
            for (int i = 0; i < 80; i++) begin
                cur = rand_stim();
                settle();
                advance();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
